// File: rtl/btn_event_gen.sv
// Button event generator: turns a debounced, clk-synchronous button level into
// one-cycle press/release/short/long/repeat strobes plus a registered held level.
module btn_event_gen #(
  parameter int unsigned LONG_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  parameter int unsigned CNT_W         = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_level,
  input  logic repeat_en,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  // The counter reads 0 on the first edge after entering DOWN/LONG, so the
  // terminal value is one less than the period to land exactly on the period.
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DOWN = 2'd1,
    ST_LONG = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_q;
  logic             rep_en_q;

  logic press_d, release_d, short_d, long_d, repeat_d, held_d;

  // State, counter and registered inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      btn_q    <= 1'b0;
      rep_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      btn_q    <= btn_level;
      rep_en_q <= repeat_en;
    end
  end

  // Next state, counter and strobe decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (btn_level && !btn_q) begin
          state_d = ST_DOWN;
          cnt_d   = '0;
          press_d = 1'b1;
        end
      end

      ST_DOWN: begin
        if (!btn_level) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
          short_d   = 1'b1;
        end else if (cnt_q == LONG_LAST) begin
          state_d = ST_LONG;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_LONG: begin
        if (!btn_level) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else if (!repeat_en || !rep_en_q) begin
          // Disabled, or first cycle after enable: restart the repeat period.
          cnt_d = '0;
        end else if (cnt_q == REP_LAST) begin
          cnt_d    = '0;
          repeat_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    held_d = (state_d == ST_LONG);
  end

  // Registered outputs; async reset clears them without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      press_pulse   <= press_d;
      release_pulse <= release_d;
      short_pulse   <= short_d;
      long_pulse    <= long_d;
      repeat_pulse  <= repeat_d;
      held          <= held_d;
    end
  end

endmodule

// File: tb/tb_btn_event_gen.sv
// Scoreboard bench for btn_event_gen with LONG_CYCLES=8, REPEAT_CYCLES=4.
module tb_btn_event_gen;

  localparam int L = 8;
  localparam int R = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_level;
  logic repeat_en;
  logic press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held;

  int checks = 0;
  int errors = 0;

  // Expected output vector order: {press, release, short, long, repeat, held}
  logic [5:0] exp_q[$];
  logic [5:0] obs;
  assign obs = {press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held};

  btn_event_gen #(
    .LONG_CYCLES  (L),
    .REPEAT_CYCLES(R),
    .CNT_W        (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_level    (btn_level),
    .repeat_en    (repeat_en),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .short_pulse  (short_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .held         (held)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] ev(input bit p, input bit r, input bit s,
                                    input bit l, input bit rp, input bit h);
    return {p, r, s, l, rp, h};
  endfunction

  // One cycle of stimulus: inputs for the next edge plus the outputs expected after it.
  task automatic drive(input logic b, input logic re, input logic [5:0] e);
    @(negedge clk);
    btn_level = b;
    repeat_en = re;
    exp_q.push_back(e);
  endtask

  // Hold the button for hc edges (k = 0..hc-1), repeat_en high for ren_lo <= k < ren_hi,
  // expected repeat strobes at the edge offsets set in rep_mask; optionally release.
  task automatic hold_seq(input int hc, input int ren_lo, input int ren_hi,
                          input logic [63:0] rep_mask, input bit do_rel);
    for (int k = 0; k < hc; k++) begin
      drive(1'b1, logic'(k >= ren_lo && k < ren_hi),
            ev(k == 0, 1'b0, 1'b0, k == L, rep_mask[k], k >= L));
    end
    if (do_rel) begin
      drive(1'b0, 1'b0, ev(1'b0, 1'b1, hc <= L, 1'b0, 1'b0, 1'b0));
      drive(1'b0, 1'b0, 6'b0);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (obs !== 6'b0) begin
      errors++;
      $display("FAIL %s: outputs got %b, required 000000 at t=%0t", name, obs, $time);
    end
  endtask

  // Monitor: compare every presented output cycle against the scoreboard head.
  initial begin
    logic [5:0] e;
    int hot;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL out_vec: got %b, required %b ({press,rel,short,long,rep,held}) t=%0t",
                   obs, e, $time);
        end
        hot = int'(press_pulse) + int'(release_pulse) + int'(long_pulse) + int'(repeat_pulse);
        checks++;
        if (hot > 1 || (short_pulse && !release_pulse)) begin
          errors++;
          $display("FAIL strobe_excl: got %b, required at most one of press/rel/long/rep t=%0t",
                   obs, $time);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    logic [63:0] m4;
    logic [63:0] m5;
    m4 = (64'd1 << 12) | (64'd1 << 16) | (64'd1 << 20) | (64'd1 << 24);
    m5 = 64'd1 << 18;

    rst_n     = 1'b0;
    btn_level = 1'b0;
    repeat_en = 1'b0;
    #12;
    check_zero("reset_state");
    #5 rst_n = 1'b1;

    // 1. Async reset mid-LONG, button held through reset release.
    hold_seq(10, 0, 0, 64'd0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset_mid_long");
    #1 rst_n = 1'b1;
    hold_seq(10, 0, 0, 64'd0, 1'b1);

    // 2. Short click of 3 cycles.
    hold_seq(3, 0, 0, 64'd0, 1'b1);

    // 3. Threshold race: release at the long edge, then hold one cycle longer.
    hold_seq(8, 0, 0, 64'd0, 1'b1);
    hold_seq(9, 0, 0, 64'd0, 1'b1);

    // 4. Auto-repeat while held for 25 cycles.
    hold_seq(25, 0, 100, m4, 1'b1);

    // 5. repeat_en gating: high only for edges 14..18.
    hold_seq(24, 14, 19, m5, 1'b1);

    // 6. Minimum-width presses back to back.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      drive(1'b0, 1'b0, ev(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    end
    drive(1'b0, 1'b0, 6'b0);
    drive(1'b0, 1'b0, 6'b0);

    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
